// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU sequencer and the ALU:
// default widths, opcode values, FSM state encoding and opcode check.
package uart_alu_pkg;

  localparam int NB_DATA_DEFAULT = 8;
  localparam int NB_OP_DEFAULT   = 6;
  localparam int NB_STATE        = 3;

  typedef logic [NB_OP_DEFAULT-1:0] op_t;

  localparam op_t OP_ADD = 6'h20;
  localparam op_t OP_SUB = 6'h22;
  localparam op_t OP_AND = 6'h24;
  localparam op_t OP_OR  = 6'h25;
  localparam op_t OP_XOR = 6'h26;
  localparam op_t OP_NOR = 6'h27;
  localparam op_t OP_SRA = 6'h03;
  localparam op_t OP_SRL = 6'h02;

  typedef enum logic [NB_STATE-1:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  // True when the opcode field names an operation the ALU implements.
  function automatic logic is_valid_op(input op_t op);
    logic valid;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: valid = 1'b1;
      default:                        valid = 1'b0;
    endcase
    return valid;
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of the sequencer's connections to rx_uart, the ALU and tx_uart.
// master: the sequencer itself; slave: the surrounding UART/ALU logic.
interface uart_alu_ctrl_if
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEFAULT,
  parameter int NB_OP   = NB_OP_DEFAULT
);

  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done_tick;
  logic               i_tx_done_tick;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_err_opcode;
  logic               o_err_timeout;

  modport master (
    input  i_rx_data, i_rx_done_tick, i_tx_done_tick, i_alu_result,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start,
           o_busy, o_err_opcode, o_err_timeout
  );

  modport slave (
    output i_rx_data, i_rx_done_tick, i_tx_done_tick, i_alu_result,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start,
           o_busy, o_err_opcode, o_err_timeout
  );

endinterface

// File: rtl/uart_alu_ctrl_frame_timeout.sv
// Inter-byte timeout: a down-counter reloaded on every accepted byte and
// decremented while the sequencer waits for the rest of the frame.
// The window is counted from the cycle of the accepting tick, so expire is
// raised one cycle ahead; the registered error then lands on the cycle in
// which TIMEOUT_CYCLES-1 cycles have elapsed since that tick.
module frame_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int                NB_CNT = $clog2(TIMEOUT_CYCLES);
  localparam logic [NB_CNT-1:0] WINDOW = NB_CNT'(TIMEOUT_CYCLES - 2);
  localparam logic [NB_CNT-1:0] LAST   = NB_CNT'(1);

  logic [NB_CNT-1:0] count_r;

  // Remaining-cycles counter; clear wins over load, load over decrement, never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= WINDOW;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - LAST;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = en && (count_r == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between rx_uart, the ALU and tx_uart: collects operand A,
// operand B and opcode, runs the ALU for one cycle and hands the result to
// tx_uart. Bad opcodes and stalled frames return it to WAIT_A.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEFAULT,
  parameter int NB_OP          = NB_OP_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  uart_alu_ctrl_if.master   bus
);

  state_t             state_r,       state_nxt_s;
  logic [NB_DATA-1:0] alu_a_r,       alu_a_nxt_s;
  logic [NB_DATA-1:0] alu_b_r,       alu_b_nxt_s;
  logic [NB_OP-1:0]   alu_op_r,      alu_op_nxt_s;
  logic [NB_DATA-1:0] tx_data_r,     tx_data_nxt_s;
  logic               tx_start_r,    tx_start_nxt_s;
  logic               busy_r,        busy_nxt_s;
  logic               err_opcode_r,  err_opcode_nxt_s;
  logic               err_timeout_r, err_timeout_nxt_s;

  op_t  op_field_s;
  logic in_window_s;
  logic tmr_load_s;
  logic tmr_clr_s;
  logic tmr_en_s;
  logic tmr_expire_s;

  // Upper bits of the opcode byte carry no meaning and are dropped here.
  assign op_field_s  = bus.i_rx_data[NB_OP-1:0];
  assign in_window_s = (state_r == WAIT_B) || (state_r == WAIT_OP);
  assign tmr_en_s    = in_window_s && !bus.i_rx_done_tick;
  assign tmr_load_s  = bus.i_rx_done_tick && ((state_r == WAIT_A) || (state_r == WAIT_B));
  assign tmr_clr_s   = (bus.i_rx_done_tick && (state_r == WAIT_OP)) ||
                       ((state_nxt_s == WAIT_A) && (state_r != WAIT_A));

  frame_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_timeout (
    .clk    (i_clock),
    .rst_n  (i_reset),
    .load   (tmr_load_s),
    .clr    (tmr_clr_s),
    .en     (tmr_en_s),
    .expire (tmr_expire_s)
  );

  // Next state and next register values; a received byte beats a timeout in the same cycle.
  always_comb begin
    state_nxt_s       = state_r;
    alu_a_nxt_s       = alu_a_r;
    alu_b_nxt_s       = alu_b_r;
    alu_op_nxt_s      = alu_op_r;
    tx_data_nxt_s     = tx_data_r;
    tx_start_nxt_s    = 1'b0;
    err_opcode_nxt_s  = 1'b0;
    err_timeout_nxt_s = 1'b0;
    case (state_r)
      WAIT_A: begin
        if (bus.i_rx_done_tick) begin
          alu_a_nxt_s = bus.i_rx_data;
          state_nxt_s = WAIT_B;
        end else begin
          state_nxt_s = WAIT_A;
        end
      end
      WAIT_B: begin
        if (bus.i_rx_done_tick) begin
          alu_b_nxt_s = bus.i_rx_data;
          state_nxt_s = WAIT_OP;
        end else if (tmr_expire_s) begin
          err_timeout_nxt_s = 1'b1;
          state_nxt_s       = WAIT_A;
        end else begin
          state_nxt_s = WAIT_B;
        end
      end
      WAIT_OP: begin
        if (bus.i_rx_done_tick) begin
          if (is_valid_op(op_field_s)) begin
            alu_op_nxt_s = op_field_s;
            state_nxt_s  = EXEC;
          end else begin
            err_opcode_nxt_s = 1'b1;
            state_nxt_s      = WAIT_A;
          end
        end else if (tmr_expire_s) begin
          err_timeout_nxt_s = 1'b1;
          state_nxt_s       = WAIT_A;
        end else begin
          state_nxt_s = WAIT_OP;
        end
      end
      EXEC: begin
        tx_data_nxt_s  = bus.i_alu_result;
        tx_start_nxt_s = 1'b1;
        state_nxt_s    = SEND;
      end
      SEND: begin
        tx_start_nxt_s = 1'b0;
        state_nxt_s    = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.i_tx_done_tick) begin
          state_nxt_s = WAIT_A;
        end else begin
          state_nxt_s = WAIT_TX;
        end
      end
      default: begin
        state_nxt_s = WAIT_A;
      end
    endcase
    busy_nxt_s = (state_nxt_s != WAIT_A);
  end

  // State and output registers; reset discards any frame in progress.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r       <= WAIT_A;
      alu_a_r       <= '0;
      alu_b_r       <= '0;
      alu_op_r      <= '0;
      tx_data_r     <= '0;
      tx_start_r    <= 1'b0;
      busy_r        <= 1'b0;
      err_opcode_r  <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      alu_a_r       <= alu_a_nxt_s;
      alu_b_r       <= alu_b_nxt_s;
      alu_op_r      <= alu_op_nxt_s;
      tx_data_r     <= tx_data_nxt_s;
      tx_start_r    <= tx_start_nxt_s;
      busy_r        <= busy_nxt_s;
      err_opcode_r  <= err_opcode_nxt_s;
      err_timeout_r <= err_timeout_nxt_s;
    end
  end

  assign bus.o_alu_a       = alu_a_r;
  assign bus.o_alu_b       = alu_b_r;
  assign bus.o_alu_op      = alu_op_r;
  assign bus.o_tx_data     = tx_data_r;
  assign bus.o_tx_start    = tx_start_r;
  assign bus.o_busy        = busy_r;
  assign bus.o_err_opcode  = err_opcode_r;
  assign bus.o_err_timeout = err_timeout_r;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a behavioural ALU and a 64-cycle timeout.
// Cycle numbering: the cycle carrying an rx tick is N, the next one N+1, etc.
module tb_uart_alu_ctrl;
  import uart_alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  uart_alu_ctrl_if bus ();

  uart_alu_ctrl #(
    .NB_DATA        (8),
    .NB_OP          (6),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Combinational ALU the sequencer drives in the real top.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic [7:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SRA:  r = $signed(a) >>> b;
      OP_SRL:  r = a >> b;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_comb bus.i_alu_result = alu_model(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data      = b;
    bus.i_rx_done_tick = 1'b1;
    step();
    bus.i_rx_done_tick = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  // Called in cycle N+1 after the opcode tick; k returns the cycle index (N+k) of o_tx_start, -1 if never.
  task automatic wait_tx_start(output int k, output logic [7:0] d);
    k = 1;
    while (!bus.o_tx_start && k < 20) begin
      step();
      k++;
    end
    if (!bus.o_tx_start) k = -1;
    d = bus.o_tx_data;
  endtask

  // From the SEND cycle: move into WAIT_TX, then give one tx_done pulse.
  task automatic finish_tx();
    step();
    bus.i_tx_done_tick = 1'b1;
    step();
    bus.i_tx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    step();
    step();
    vectors++;
    if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data, bus.o_tx_start, bus.o_busy,
         bus.o_err_opcode, bus.o_err_timeout} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got a=%h b=%h op=%h tx=%h start=%b busy=%b eop=%b eto=%b, want all 0",
               bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data, bus.o_tx_start, bus.o_busy,
               bus.o_err_opcode, bus.o_err_timeout);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    step();
    vectors++;
    if ({bus.o_busy, bus.o_tx_start} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b start=%b, want 0 0", bus.o_busy, bus.o_tx_start);
    end
  endtask

  task automatic test_add();
    int k;
    logic [7:0] d;
    send_byte(8'h55);
    vectors++;
    if ({bus.o_alu_a, bus.o_busy} !== {8'h55, 1'b1}) begin
      miscompares++;
      $display("FAIL add_a: got a=%h busy=%b, want 55 1", bus.o_alu_a, bus.o_busy);
    end
    send_byte(8'h01);
    send_byte(8'h20);
    vectors++;
    if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_start} !== {8'h55, 8'h01, 6'h20, 1'b0}) begin
      miscompares++;
      $display("FAIL add_operands: got a=%h b=%h op=%h start=%b, want 55 01 20 0",
               bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_start);
    end
    wait_tx_start(k, d);
    vectors++;
    if (k !== 2) begin
      miscompares++;
      $display("FAIL add_latency: got N+%0d, want N+2", k);
    end
    vectors++;
    if (d !== 8'h56) begin
      miscompares++;
      $display("FAIL add_result: got %h, want 56", d);
    end
    step();
    vectors++;
    if ({bus.o_tx_start, bus.o_tx_data} !== {1'b0, 8'h56}) begin
      miscompares++;
      $display("FAIL add_pulse_width: got start=%b tx=%h, want 0 56", bus.o_tx_start, bus.o_tx_data);
    end
    repeat (4) step();
    vectors++;
    if ({bus.o_busy, bus.o_tx_data, bus.o_tx_start} !== {1'b1, 8'h56, 1'b0}) begin
      miscompares++;
      $display("FAIL add_hold: got busy=%b tx=%h start=%b, want 1 56 0", bus.o_busy, bus.o_tx_data, bus.o_tx_start);
    end
    bus.i_tx_done_tick = 1'b1;
    step();
    bus.i_tx_done_tick = 1'b0;
    vectors++;
    if (bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL add_done: got busy=%b, want 0", bus.o_busy);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [7:0] d;
    send_frame(8'h0F, 8'h03, 8'h22);
    wait_tx_start(k, d);
    vectors++;
    if ({k == 2, d} !== {1'b1, 8'h0C}) begin
      miscompares++;
      $display("FAIL b2b_sub: got N+%0d data=%h, want N+2 0c", k, d);
    end
    finish_tx();
    send_frame(8'h80, 8'h02, 8'h03);
    wait_tx_start(k, d);
    vectors++;
    if ({k == 2, d, bus.o_alu_op} !== {1'b1, 8'hE0, 6'h03}) begin
      miscompares++;
      $display("FAIL b2b_sra: got N+%0d data=%h op=%h, want N+2 e0 03", k, d, bus.o_alu_op);
    end
    finish_tx();
  endtask

  task automatic test_bad_opcode();
    int k;
    int starts;
    logic [7:0] d;
    send_frame(8'h10, 8'h20, 8'h3F);
    vectors++;
    if ({bus.o_err_opcode, bus.o_busy, bus.o_alu_a, bus.o_alu_b, bus.o_alu_op} !==
        {1'b1, 1'b0, 8'h10, 8'h20, 6'h03}) begin
      miscompares++;
      $display("FAIL badop_flag: got eop=%b busy=%b a=%h b=%h op=%h, want 1 0 10 20 03",
               bus.o_err_opcode, bus.o_busy, bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
    end
    starts = 0;
    step();
    vectors++;
    if (bus.o_err_opcode !== 1'b0) begin
      miscompares++;
      $display("FAIL badop_pulse: got eop=%b, want 0", bus.o_err_opcode);
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.o_tx_start) starts++;
      step();
    end
    vectors++;
    if (starts !== 0) begin
      miscompares++;
      $display("FAIL badop_no_tx: got %0d starts, want 0", starts);
    end
    send_frame(8'h01, 8'h01, 8'h20);
    wait_tx_start(k, d);
    vectors++;
    if ({k == 2, d} !== {1'b1, 8'h02}) begin
      miscompares++;
      $display("FAIL badop_recover: got N+%0d data=%h, want N+2 02", k, d);
    end
    finish_tx();
  endtask

  task automatic test_timeout();
    int k;
    int pulses;
    logic [7:0] d;
    send_byte(8'hAA);
    k = 1;
    while (!bus.o_err_timeout && k < 200) begin
      step();
      k++;
    end
    vectors++;
    if ({k == 63, bus.o_busy} !== {1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL timeout_cycle: got N+%0d busy=%b, want N+63 0", k, bus.o_busy);
    end
    step();
    vectors++;
    if (bus.o_err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: got eto=%b, want 0", bus.o_err_timeout);
    end
    send_frame(8'h01, 8'h02, 8'h20);
    wait_tx_start(k, d);
    vectors++;
    if ({k == 2, d} !== {1'b1, 8'h03}) begin
      miscompares++;
      $display("FAIL timeout_recover: got N+%0d data=%h, want N+2 03", k, d);
    end
    finish_tx();
    // A byte arriving in the last cycle before the deadline (N+62) must win.
    send_byte(8'h05);
    pulses = 0;
    for (int i = 0; i < 61; i++) begin
      if (bus.o_err_timeout) pulses++;
      step();
    end
    send_byte(8'h06);
    step();
    if (bus.o_err_timeout) pulses++;
    vectors++;
    if ({pulses == 0, bus.o_busy, bus.o_alu_b} !== {1'b1, 1'b1, 8'h06}) begin
      miscompares++;
      $display("FAIL timeout_edge_tick: got pulses=%0d busy=%b b=%h, want 0 1 06", pulses, bus.o_busy, bus.o_alu_b);
    end
    send_byte(8'h20);
    wait_tx_start(k, d);
    vectors++;
    if (d !== 8'h0B) begin
      miscompares++;
      $display("FAIL timeout_edge_result: got %h, want 0b", d);
    end
    finish_tx();
  endtask

  task automatic test_extra_rx();
    int k;
    logic [7:0] d;
    send_frame(8'h33, 8'h11, 8'h24);
    wait_tx_start(k, d);
    step();
    send_byte(8'h99);
    vectors++;
    if ({d, bus.o_tx_data, bus.o_alu_a, bus.o_busy} !== {8'h11, 8'h11, 8'h33, 1'b1}) begin
      miscompares++;
      $display("FAIL extra_rx_ignored: got sent=%h tx=%h a=%h busy=%b, want 11 11 33 1",
               d, bus.o_tx_data, bus.o_alu_a, bus.o_busy);
    end
    bus.i_tx_done_tick = 1'b1;
    step();
    bus.i_tx_done_tick = 1'b0;
    send_byte(8'h07);
    vectors++;
    if ({bus.o_alu_a, bus.o_busy} !== {8'h07, 1'b1}) begin
      miscompares++;
      $display("FAIL extra_rx_new_a: got a=%h busy=%b, want 07 1", bus.o_alu_a, bus.o_busy);
    end
    send_byte(8'h02);
    send_byte(8'hC2);
    wait_tx_start(k, d);
    vectors++;
    if ({bus.o_alu_op, d} !== {6'h02, 8'h01}) begin
      miscompares++;
      $display("FAIL extra_rx_srl_upper_bits: got op=%h data=%h, want 02 01", bus.o_alu_op, d);
    end
    finish_tx();
  endtask

  task automatic test_reset_mid();
    int k;
    logic [7:0] d;
    send_byte(8'h02);
    send_byte(8'h03);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data, bus.o_tx_start, bus.o_busy,
         bus.o_err_opcode, bus.o_err_timeout} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_wait_op: got a=%h b=%h busy=%b, want all 0", bus.o_alu_a, bus.o_alu_b, bus.o_busy);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    send_frame(8'h02, 8'h03, 8'h20);
    wait_tx_start(k, d);
    vectors++;
    if ({k == 2, d} !== {1'b1, 8'h05}) begin
      miscompares++;
      $display("FAIL reset_wait_op_recover: got N+%0d data=%h, want N+2 05", k, d);
    end
    finish_tx();
    send_frame(8'h0C, 8'h0A, 8'h26);
    wait_tx_start(k, d);
    step();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({d, bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data, bus.o_tx_start, bus.o_busy,
         bus.o_err_opcode, bus.o_err_timeout} !== {8'h06, 34'h0}) begin
      miscompares++;
      $display("FAIL reset_wait_tx: got sent=%h tx=%h a=%h busy=%b, want 06 then all 0",
               d, bus.o_tx_data, bus.o_alu_a, bus.o_busy);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    send_frame(8'h20, 8'h22, 8'h20);
    wait_tx_start(k, d);
    vectors++;
    if ({k == 2, d} !== {1'b1, 8'h42}) begin
      miscompares++;
      $display("FAIL reset_wait_tx_recover: got N+%0d data=%h, want N+2 42", k, d);
    end
    finish_tx();
  endtask

  initial begin
    bus.i_rx_data      = 8'h00;
    bus.i_rx_done_tick = 1'b0;
    bus.i_tx_done_tick = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_bad_opcode();
    test_timeout();
    test_extra_rx();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
